// File: rtl/adc_avg_fifo_10b.sv
// Averages 1/2/4/8 SAR conversions per window and queues each averaged word in a small FIFO.
// adc_done comes from another clock domain and is synchronised before it is edge-detected.
module adc_avg_fifo_10b #(
    parameter int DW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clkin,
    input  logic          rst_n,
    input  logic          adc_done,
    input  logic [DW-1:0] result,
    input  logic [1:0]    avg_sel,
    input  logic          clr,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          full,
    output logic [2:0]    level,
    output logic          overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_L = 3'(DEPTH);

    typedef enum logic {
        sIdle,
        sAcc
    } state_t;

    logic          sync1_q, sync2_q, sync3_q;
    logic          capture;

    state_t        state_q, state_d;
    logic [1:0]    win_sel_q, win_sel_d;
    logic [DW+2:0] acc_q, acc_d;
    logic [2:0]    cnt_q, cnt_d;

    logic [1:0]    sel_eff;
    logic [DW+2:0] sum;
    logic [3:0]    cnt_inc;
    logic [DW-1:0] avg_word;
    logic          push;
    logic [DW-1:0] push_data;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [2:0]    level_q;
    logic          overflow_q;
    logic          pop;
    logic          do_write;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= adc_done;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign capture = sync2_q & ~sync3_q;

    // The window size is taken live from avg_sel only on the capture that opens a window.
    assign sel_eff = (state_q == sIdle) ? avg_sel : win_sel_q;
    assign sum     = acc_q + {3'b000, result};
    assign cnt_inc = {1'b0, cnt_q} + 4'd1;

    always_comb begin
        avg_word = sum[DW-1:0];
        case (sel_eff)
            2'd0: avg_word = sum[DW-1:0];
            2'd1: avg_word = sum[DW:1];
            2'd2: avg_word = sum[DW+1:2];
            2'd3: avg_word = sum[DW+2:3];
            default: avg_word = sum[DW-1:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        win_sel_d = win_sel_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = avg_word;
        if (clr) begin
            state_d = sIdle;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (capture) begin
            win_sel_d = sel_eff;
            if (cnt_inc == (4'd1 << sel_eff)) begin
                push    = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = sIdle;
            end else begin
                acc_d   = sum;
                cnt_d   = cnt_inc[2:0];
                state_d = sAcc;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= sIdle;
            win_sel_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            win_sel_q <= win_sel_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign valid    = (level_q != 3'd0);
    assign full     = (level_q == DEPTH_L);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign dout     = mem_q[rptr_q];

    // A push into a full FIFO is only accepted when a pop frees the head slot in the same edge.
    assign pop      = rd_en & valid & ~clr;
    assign do_write = push & (~full | pop);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_write && !pop) begin
                level_q <= level_q + 3'd1;
            end else if (pop && !do_write) begin
                level_q <= level_q - 3'd1;
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (do_write) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_adc_avg_fifo_10b.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a queue-based model of the averaging FIFO.
module tb_adc_avg_fifo_10b;

    logic       clkin = 1'b0;
    logic       rst_n;
    logic       adc_done;
    logic [9:0] result;
    logic [1:0] avg_sel;
    logic       clr;
    logic       rd_en;
    logic [9:0] dout;
    logic       valid;
    logic       full;
    logic [2:0] level;
    logic       overflow;

    int nVectors = 0;
    int nMiscompares = 0;

    // Model state: recent adc_done samples (index 0 newest), open window samples, FIFO contents.
    bit  doneHist[3];
    int  winSamples[$];
    int  winSel;
    int  fifoQ[$];
    bit  mOverflow;

    adc_avg_fifo_10b #(.DW(10), .DEPTH(4)) dut (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .adc_done (adc_done),
        .result   (result),
        .avg_sel  (avg_sel),
        .clr      (clr),
        .rd_en    (rd_en),
        .dout     (dout),
        .valid    (valid),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clkin = ~clkin;

    task automatic compare(input string name, input int act, input int exp);
        nVectors++;
        if (act != exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) doneHist[i] = 1'b0;
        winSamples.delete();
        fifoQ.delete();
        winSel = 0;
        mOverflow = 1'b0;
    endtask

    // One rising clkin edge: a capture happens when adc_done was seen high two edges ago
    // but low three edges ago.
    task automatic modelStep();
        bit captureNow;
        bit pushNow;
        bit popNow;
        bit wasFull;
        int pushVal;
        int total;
        if (!rst_n) begin
            modelReset();
            return;
        end
        captureNow = doneHist[1] && !doneHist[2];
        doneHist[2] = doneHist[1];
        doneHist[1] = doneHist[0];
        doneHist[0] = adc_done;
        if (clr) begin
            winSamples.delete();
            fifoQ.delete();
            mOverflow = 1'b0;
            return;
        end
        pushNow = 1'b0;
        pushVal = 0;
        if (captureNow) begin
            if (winSamples.size() == 0) winSel = int'(avg_sel);
            winSamples.push_back(int'(result));
            if (winSamples.size() == (1 << winSel)) begin
                total = 0;
                foreach (winSamples[i]) total += winSamples[i];
                pushVal = total / (1 << winSel);
                winSamples.delete();
                pushNow = 1'b1;
            end
        end
        wasFull = (fifoQ.size() == 4);
        popNow = rd_en && (fifoQ.size() > 0);
        if (popNow) void'(fifoQ.pop_front());
        if (pushNow) begin
            if (wasFull && !popNow) mOverflow = 1'b1;
            else fifoQ.push_back(pushVal);
        end
    endtask

    task automatic checkOutput();
        compare("valid", int'(valid), int'(fifoQ.size() > 0));
        compare("full", int'(full), int'(fifoQ.size() == 4));
        compare("level", int'(level), fifoQ.size());
        compare("overflow", int'(overflow), int'(mOverflow));
        if (fifoQ.size() > 0) compare("dout", int'(dout), fifoQ[0]);
    endtask

    task automatic step();
        @(posedge clkin);
        modelStep();
        #1;
        checkOutput();
        @(negedge clkin);
    endtask

    task automatic applyStimulus(input bit done, input int res, input int sel, input bit c, input bit rd);
        adc_done = done;
        result   = 10'(res);
        avg_sel  = 2'(sel);
        clr      = c;
        rd_en    = rd;
    endtask

    // Raise adc_done for hi cycles with a fixed result, then drop it for two cycles.
    // rdOnCapture asserts rd_en on the edge where the capture lands.
    task automatic pulse(input int res, input int hi, input bit rdOnCapture);
        adc_done = 1'b1;
        result   = 10'(res);
        for (int i = 0; i < hi; i++) begin
            rd_en = rdOnCapture && (i == 2);
            step();
        end
        adc_done = 1'b0;
        rd_en    = 1'b0;
        step();
        step();
    endtask

    task automatic popOne();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        int holdCnt;
        modelReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        step();
        step();
        compare("reset_valid", int'(valid), 0);
        compare("reset_level", int'(level), 0);
        compare("reset_full", int'(full), 0);
        compare("reset_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        step();
        step();
        step();

        $display("[TB] single sample, window of 1");
        applyStimulus(1'b1, 700, 0, 1'b0, 1'b0);
        step();
        step();
        compare("lat_valid_before_3rd", int'(valid), 0);
        step();
        compare("lat_valid_after_3rd", int'(valid), 1);
        compare("single_dout", int'(dout), 700);
        compare("single_level", int'(level), 1);
        adc_done = 1'b0;
        step();
        popOne();
        compare("single_pop_valid", int'(valid), 0);

        $display("[TB] window of 4");
        avg_sel = 2'd2;
        pulse(100, 3, 1'b0);
        pulse(101, 3, 1'b0);
        pulse(102, 3, 1'b0);
        compare("win4_no_early_push", int'(level), 0);
        pulse(103, 3, 1'b0);
        compare("win4_level", int'(level), 1);
        compare("win4_dout", int'(dout), 101);
        popOne();

        $display("[TB] overflow and clear");
        avg_sel = 2'd0;
        for (int k = 1; k <= 5; k++) pulse(k, 3, 1'b0);
        compare("ovf_level", int'(level), 4);
        compare("ovf_full", int'(full), 1);
        compare("ovf_flag", int'(overflow), 1);
        compare("ovf_head", int'(dout), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        compare("clr_level", int'(level), 0);
        compare("clr_overflow", int'(overflow), 0);

        $display("[TB] push and pop together while full");
        for (int k = 1; k <= 4; k++) pulse(k, 3, 1'b0);
        pulse(5, 3, 1'b1);
        compare("fullpp_level", int'(level), 4);
        compare("fullpp_overflow", int'(overflow), 0);
        compare("fullpp_head", int'(dout), 2);
        popOne();
        compare("fullpp_next3", int'(dout), 3);
        popOne();
        compare("fullpp_next4", int'(dout), 4);
        popOne();
        compare("fullpp_tail", int'(dout), 5);
        popOne();
        compare("fullpp_empty", int'(valid), 0);

        $display("[TB] reset mid-window");
        avg_sel = 2'd3;
        pulse(1023, 3, 1'b0);
        pulse(1023, 3, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        for (int k = 0; k < 7; k++) pulse(1023, 3, 1'b0);
        compare("rstwin_no_push_after7", int'(level), 0);
        pulse(1023, 3, 1'b0);
        compare("rstwin_level", int'(level), 1);
        compare("rstwin_dout", int'(dout), 1023);
        popOne();

        $display("[TB] long adc_done and mid-window avg_sel change");
        avg_sel = 2'd0;
        pulse(333, 20, 1'b0);
        compare("long_level", int'(level), 1);
        compare("long_dout", int'(dout), 333);
        popOne();
        avg_sel = 2'd2;
        pulse(10, 3, 1'b0);
        avg_sel = 2'd0;
        pulse(20, 3, 1'b0);
        pulse(30, 3, 1'b0);
        compare("selchg_no_push", int'(level), 0);
        pulse(40, 3, 1'b0);
        compare("selchg_level", int'(level), 1);
        compare("selchg_dout", int'(dout), 25);
        popOne();

        $display("[TB] randomized traffic");
        holdCnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (holdCnt == 0) begin
                if (adc_done) begin
                    adc_done = 1'b0;
                    holdCnt  = $urandom_range(1, 4);
                end else begin
                    adc_done = 1'b1;
                    result   = 10'($urandom_range(0, 1023));
                    holdCnt  = $urandom_range(3, 8);
                end
            end
            holdCnt--;
            if ($urandom_range(0, 7) == 0) avg_sel = 2'($urandom_range(0, 3));
            rd_en = ($urandom_range(0, 99) < ((cyc < 1500) ? 8 : 50));
            clr   = ($urandom_range(0, 149) == 0);
            rst_n = !($urandom_range(0, 499) == 0);
            step();
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
